// File: rtl/gate_sweep_pkg.sv
// Shared definitions for the exhaustive gate sweep tester: function codes,
// FSM state encoding and settle-counter sizing.
package gate_sweep_pkg;

    localparam int FN_NAND = 0;
    localparam int FN_NOR  = 1;
    localparam int FN_AND  = 2;
    localparam int FN_OR   = 3;
    localparam int FN_XOR  = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Counter spans 0..settle-1; keep at least one bit.
    function automatic int settle_cnt_w(input int settle);
        return (settle <= 2) ? 1 : $clog2(settle);
    endfunction

endpackage

// File: rtl/gate_ref.sv
// Combinational reference model of the gate under test, selected by FN.
module gate_ref
    import gate_sweep_pkg::*;
#(
    parameter int N  = 2,
    parameter int FN = FN_NAND
) (
    input  logic [N-1:0] vec,
    output logic         exp
);

    always_comb begin
        exp = 1'b0;
        case (FN)
            FN_NAND: exp = ~(&vec);
            FN_NOR:  exp = ~(|vec);
            FN_AND:  exp = &vec;
            FN_OR:   exp = |vec;
            default: exp = ^vec;
        endcase
    end

endmodule

// File: rtl/gate_sweep_tester.sv
// Exhaustive sweep of an N-input gate against gate_ref with mismatch counting.
// Optional GATE_SWEEP_FIRST_FAIL_EN adds a latch of the first failing vector.
//
// state     | meaning
// ST_IDLE   | after reset, waiting for start
// ST_APPLY  | vec_o driven, settling for SETTLE cycles
// ST_SAMPLE | compare gut_i with reference, advance vector
// ST_DONE   | sweep complete, results held until next start
module gate_sweep_tester
    import gate_sweep_pkg::*;
#(
    parameter int N      = 2,
    parameter int SETTLE = 1,
    parameter int FN     = FN_NAND
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic [N-1:0] vec_o,
    input  logic         gut_i,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [N:0]   err_cnt
`ifdef GATE_SWEEP_FIRST_FAIL_EN
    ,
    output logic         first_fail_vld,
    output logic [N-1:0] first_fail_vec
`endif
);

    localparam int SW = settle_cnt_w(SETTLE);
    localparam logic [SW-1:0] SETTLE_TC = SW'(SETTLE - 1);
    localparam logic [SW-1:0] CNT_ONE   = SW'(1);
    localparam logic [N-1:0]  VEC_ONE   = N'(1);
    localparam logic [N:0]    ERR_ONE   = (N + 1)'(1);

    state_t        state_q, state_d;
    logic [SW-1:0] settle_cnt;
    logic          exp;
    logic          mismatch;
    logic          settle_tc;
    logic          last_vec;
    logic          start_sweep;

    gate_ref #(.N(N), .FN(FN)) u_ref (
        .vec (vec_o),
        .exp (exp)
    );

    // An X/Z on gut_i must count as a failure, hence the case inequality.
    assign mismatch    = (gut_i !== exp);
    assign settle_tc   = (settle_cnt == SETTLE_TC);
    assign last_vec    = &vec_o;
    assign start_sweep = start && (state_q == ST_IDLE || state_q == ST_DONE);

    assign busy = (state_q == ST_APPLY) || (state_q == ST_SAMPLE);
    assign done = (state_q == ST_DONE);
    assign pass = done && (err_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (start) state_d = ST_APPLY;
            ST_APPLY:         if (settle_tc) state_d = ST_SAMPLE;
            ST_SAMPLE:        state_d = last_vec ? ST_DONE : ST_APPLY;
            default:          state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_o      <= '0;
            settle_cnt <= '0;
            err_cnt    <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        vec_o      <= '0;
                        settle_cnt <= '0;
                        err_cnt    <= '0;
                    end
                end
                ST_APPLY: settle_cnt <= settle_tc ? '0 : settle_cnt + CNT_ONE;
                ST_SAMPLE: begin
                    if (mismatch) err_cnt <= err_cnt + ERR_ONE;
                    if (!last_vec) vec_o <= vec_o + VEC_ONE;
                end
                default: ;
            endcase
        end
    end

`ifdef GATE_SWEEP_FIRST_FAIL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_fail_vld <= 1'b0;
            first_fail_vec <= '0;
        end else if (start_sweep) begin
            first_fail_vld <= 1'b0;
            first_fail_vec <= '0;
        end else if (state_q == ST_SAMPLE && mismatch && !first_fail_vld) begin
            first_fail_vld <= 1'b1;
            first_fail_vec <= vec_o;
        end
    end
`else
    logic unused_start_sweep;
    assign unused_start_sweep = start_sweep;
`endif

endmodule

// File: tb/tb_gate_sweep_tester.sv
// Directed bench: 2-input NAND sweeps with ideal/stuck GUTs, reset and restart
// cases, plus a 4-input XOR sweep with a longer settle time.
module tb_gate_sweep_tester;
    import gate_sweep_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    logic [1:0] vec_a;
    logic [3:0] vec_b;
    logic       gut_a, gut_b;
    logic       busy_a, done_a, pass_a;
    logic       busy_b, done_b, pass_b;
    logic [2:0] err_a;
    logic [4:0] err_b;
    int         mode_a = 0;
    int         n_chk = 0;
    int         n_bad = 0;
    int         edges;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
    logic       ffv_a, ffv_b;
    logic [1:0] ffvec_a;
    logic [3:0] ffvec_b;
`endif

    always #5 clk = ~clk;

    // GUT for instance A: 0 ideal NAND, 1 stuck-at-1, 2 stuck-at-0
    assign gut_a = (mode_a == 0) ? ~(&vec_a) : (mode_a == 1);
    assign gut_b = ^vec_b;

    gate_sweep_tester #(.N(2), .SETTLE(1), .FN(FN_NAND)) dut_a (
        .clk (clk), .rst_n (rst_n), .start (start_a), .vec_o (vec_a),
        .gut_i (gut_a), .busy (busy_a), .done (done_a), .pass (pass_a),
        .err_cnt (err_a)
`ifdef GATE_SWEEP_FIRST_FAIL_EN
        , .first_fail_vld (ffv_a), .first_fail_vec (ffvec_a)
`endif
    );

    gate_sweep_tester #(.N(4), .SETTLE(3), .FN(FN_XOR)) dut_b (
        .clk (clk), .rst_n (rst_n), .start (start_b), .vec_o (vec_b),
        .gut_i (gut_b), .busy (busy_b), .done (done_b), .pass (pass_b),
        .err_cnt (err_b)
`ifdef GATE_SWEEP_FIRST_FAIL_EN
        , .first_fail_vld (ffv_b), .first_fail_vec (ffvec_b)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Leaves the bench 1 time unit after the edge that sampled start.
    task automatic pulse_a(input bit hold);
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start_a = 1'b0;
    endtask

    task automatic wait_done_a(output int n);
        n = 0;
        while (!done_a && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        #1;
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_done", 32'(done_a), 0);
        chk("rst_pass", 32'(pass_a), 0);
        chk("rst_vec", 32'(vec_a), 0);
        chk("rst_err", 32'(err_a), 0);
`ifdef GATE_SWEEP_FIRST_FAIL_EN
        chk("rst_ffv", 32'(ffv_a), 0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 1: ideal NAND, check vector sequence and done timing
        mode_a = 0;
        pulse_a(1'b0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("t1_vec%0d", i), 32'(vec_a), 32'(i / 2));
            chk($sformatf("t1_busy%0d", i), 32'(busy_a), 1);
            chk($sformatf("t1_done%0d", i), 32'(done_a), 0);
        end
        @(negedge clk);
        chk("t1_done", 32'(done_a), 1);
        chk("t1_busy", 32'(busy_a), 0);
        chk("t1_err", 32'(err_a), 0);
        chk("t1_pass", 32'(pass_a), 1);

        // 2: stuck-at-1 fails only at vector 11
        mode_a = 1;
        pulse_a(1'b0);
        wait_done_a(edges);
        chk("t2_edges", 32'(edges), 8);
        chk("t2_err", 32'(err_a), 1);
        chk("t2_pass", 32'(pass_a), 0);
`ifdef GATE_SWEEP_FIRST_FAIL_EN
        chk("t2_ffv", 32'(ffv_a), 1);
        chk("t2_ffvec", 32'(ffvec_a), 3);
`endif

        // 3: stuck-at-0 fails at 00, 01, 10
        mode_a = 2;
        pulse_a(1'b0);
`ifdef GATE_SWEEP_FIRST_FAIL_EN
        chk("t3_ffv_clr", 32'(ffv_a), 0);
`endif
        wait_done_a(edges);
        chk("t3_edges", 32'(edges), 8);
        chk("t3_err", 32'(err_a), 3);
        chk("t3_pass", 32'(pass_a), 0);
`ifdef GATE_SWEEP_FIRST_FAIL_EN
        chk("t3_ffv", 32'(ffv_a), 1);
        chk("t3_ffvec", 32'(ffvec_a), 0);
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("t3_err_hold", 32'(err_a), 3);
        chk("t3_done_hold", 32'(done_a), 1);

        // 5b: start from DONE with err_cnt=3 clears it and re-sweeps
        mode_a = 0;
        pulse_a(1'b0);
        chk("t5b_err_clr", 32'(err_a), 0);
        chk("t5b_done_clr", 32'(done_a), 0);
        chk("t5b_busy", 32'(busy_a), 1);
        chk("t5b_vec", 32'(vec_a), 0);
        wait_done_a(edges);
        chk("t5b_edges", 32'(edges), 8);
        chk("t5b_pass", 32'(pass_a), 1);

        // 5a: start held high through the sweep does not restart it
        pulse_a(1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk("t5a_vec_mid", 32'(vec_a), 2);
        edges = 4;
        while (!done_a && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
        end
        start_a = 1'b0;
        chk("t5a_edges", 32'(edges), 8);
        chk("t5a_pass", 32'(pass_a), 1);
        @(negedge clk);
        chk("t5a_done_stay", 32'(done_a), 1);

        // 4: async reset mid-sweep with a failing GUT
        mode_a = 2;
        pulse_a(1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("t4_err_pre", 32'(err_a), 1);
        chk("t4_busy_pre", 32'(busy_a), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t4_busy_rst", 32'(busy_a), 0);
        chk("t4_vec_rst", 32'(vec_a), 0);
        chk("t4_err_rst", 32'(err_a), 0);
        chk("t4_done_rst", 32'(done_a), 0);
        @(negedge clk);
        rst_n = 1'b1;
        mode_a = 0;
        pulse_a(1'b0);
        wait_done_a(edges);
        chk("t4_edges", 32'(edges), 8);
        chk("t4_pass", 32'(pass_a), 1);

        // 6: 4-input XOR, SETTLE=3 -> 16 vectors x 4 cycles
        @(negedge clk);
        start_b = 1'b1;
        @(posedge clk);
        #1;
        start_b = 1'b0;
        chk("t6_vec0", 32'(vec_b), 0);
        edges = 0;
        while (!done_b && edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
            if (edges == 32) chk("t6_vec_mid", 32'(vec_b), 8);
        end
        chk("t6_edges", 32'(edges), 64);
        chk("t6_vec_last", 32'(vec_b), 15);
        chk("t6_err", 32'(err_b), 0);
        chk("t6_pass", 32'(pass_b), 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
